manchester_decoder: RTL and testbench

//   Receive-side partner of the Manchester encoder FSM: recovers the data bits from an

---
 rtl/manchester_pkg.sv | 16 +
 rtl/manchester_sync.sv | 35 +++
 rtl/manchester_decoder.sv | 179 +++++++++++++++++
 tb/tb_manchester_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared types and symbol encodings for the Manchester receive path.
// A symbol is {first half, second half} as sampled on the line.
package manchester_pkg;

  typedef enum logic [1:0] {
    IDLE,
    H1,
    H2
  } dec_state_t;

  localparam logic [1:0] SYM_ZERO = 2'b10;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_BAD  = 2'b11;

endpackage

// File: rtl/manchester_sync.sv
// Brings the asynchronous Manchester line into the clk domain and provides
// the synchronised level, its one-cycle delayed copy and a change strobe.
module manchester_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic ls_o,
  output logic ls_d_o,
  output logic edge_o
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("manchester_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ls_d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      ls_d_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      ls_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ls_o   = sync_q[SYNC_STAGES-1];
  assign ls_d_o = ls_d_q;
  assign edge_o = sync_q[SYNC_STAGES-1] ^ ls_d_q;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester line decoder: frames on a "10" start symbol, re-aligns on mid-bit
// edges and emits one registered bit per symbol with error / end-of-frame pulses.
module manchester_decoder
  import manchester_pkg::*;
#(
  parameter int HALF_CLKS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic bit_out,
  output logic bit_valid,
  output logic locked,
  output logic code_err,
  output logic frame_end
);

  if (HALF_CLKS < 4) begin : g_bad_half
    $error("manchester_decoder: HALF_CLKS must be at least 4");
  end

  localparam int              CW       = $clog2(HALF_CLKS);
  localparam logic [CW-1:0]   CNT_MID  = CW'(HALF_CLKS / 2);
  localparam logic [CW-1:0]   CNT_LAST = CW'(HALF_CLKS - 1);

  logic ls;
  logic ls_d;
  logic line_edge;

  manchester_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line_i  (line_in),
    .ls_o    (ls),
    .ls_d_o  (ls_d),
    .edge_o  (line_edge)
  );

  dec_state_t    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          s1_q,        s1_d;
  logic          s2_q,        s2_d;
  logic          start_q,     start_d;
  logic          bit_out_q,   bit_out_d;
  logic          bit_valid_q, bit_valid_d;
  logic          locked_q,    locked_d;
  logic          code_err_q,  code_err_d;
  logic          frame_end_q, frame_end_d;
  logic [1:0]    sym;

  assign sym = {s1_q, s2_q};

  // bit_valid is a single-cycle qualifier with no back-pressure: bit_out is
  // only meaningful in the cycle bit_valid is high and the consumer must take it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    start_d     = start_q;
    bit_out_d   = bit_out_q;
    locked_d    = locked_q;
    bit_valid_d = 1'b0;
    code_err_d  = 1'b0;
    frame_end_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ls && !ls_d) begin
          state_d = H1;
          start_d = 1'b1;
        end
      end

      H1: begin
        cnt_d = cnt_q + 1'b1;
        // The counter restarts the cycle after an edge, so the delayed line
        // copy is the level that lines up with the count.
        if (cnt_q == CNT_MID) begin
          s1_d = ls_d;
        end
        if ((line_edge && (cnt_q > CNT_MID)) || (cnt_q == CNT_LAST)) begin
          state_d = H2;
          cnt_d   = '0;
        end
      end

      H2: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MID) begin
          s2_d = ls_d;
        end
        if (line_edge && (cnt_q < CNT_MID)) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (start_q) begin
            if (sym == SYM_ZERO) begin
              start_d  = 1'b0;
              locked_d = 1'b1;
              state_d  = H1;
            end else begin
              start_d    = 1'b0;
              code_err_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            case (sym)
              SYM_ZERO: begin
                bit_out_d   = 1'b0;
                bit_valid_d = 1'b1;
                state_d     = H1;
              end
              SYM_ONE: begin
                bit_out_d   = 1'b1;
                bit_valid_d = 1'b1;
                state_d     = H1;
              end
              SYM_BAD: begin
                code_err_d = 1'b1;
                locked_d   = 1'b0;
                state_d    = IDLE;
              end
              SYM_IDLE: begin
                frame_end_d = 1'b1;
                locked_d    = 1'b0;
                state_d     = IDLE;
              end
            endcase
          end
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        start_d  = 1'b0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      start_q     <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      code_err_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      start_q     <= start_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      locked_q    <= locked_d;
      code_err_q  <= code_err_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign locked    = locked_q;
  assign code_err  = code_err_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_manchester_decoder.sv
// Directed bench for manchester_decoder: drives Manchester frames from a
// behavioural line model and scores decoded bits and flag pulses.
module tb_manchester_decoder;
  import manchester_pkg::*;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic line_in;
  logic bit_out;
  logic bit_valid;
  logic locked;
  logic code_err;
  logic frame_end;

  always #5 clk = ~clk;

  manchester_decoder #(
    .HALF_CLKS   (HALF),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_in   (line_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .locked    (locked),
    .code_err  (code_err),
    .frame_end (frame_end)
  );

  int n_checks = 0;
  int n_errors = 0;

  int   cyc        = 0;
  int   n_valid    = 0;
  int   n_err      = 0;
  int   n_end      = 0;
  int   n_excl     = 0;
  int   n_lock_cyc = 0;
  logic bit_log   [0:255];
  int   valid_cyc [0:255];

  logic [0:0] exp_q[$];

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bit_valid) begin
      if (n_valid < 256) begin
        bit_log[n_valid]   <= bit_out;
        valid_cyc[n_valid] <= cyc;
      end
      n_valid <= n_valid + 1;
    end
    if (code_err)  n_err <= n_err + 1;
    if (frame_end) n_end <= n_end + 1;
    if (locked)    n_lock_cyc <= n_lock_cyc + 1;
    if (int'(bit_valid) + int'(code_err) + int'(frame_end) > 1) n_excl <= n_excl + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int outs();
    return int'({bit_out, bit_valid, locked, code_err, frame_end});
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic half(input logic lvl, input int n);
    line_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] sym, input int h1, input int h2);
    half(sym[1], h1);
    half(sym[0], h2);
  endtask

  task automatic send_bit(input logic b, input int h1, input int h2);
    exp_q.push_back(b);
    send_sym(b ? SYM_ONE : SYM_ZERO, h1, h2);
  endtask

  task automatic check_frame(input string tag, input int v0, input int e0, input int f0,
                             input int exp_err, input int exp_end, input bit spacing);
    int         nb;
    int         got;
    logic [0:0] e;
    nb  = exp_q.size();
    got = n_valid - v0;
    check($sformatf("%s_nbits", tag), got, nb);
    for (int i = 0; i < nb; i++) begin
      e = exp_q.pop_front();
      if (i < got && (v0 + i) < 256) begin
        check($sformatf("%s_bit%0d", tag, i), int'(bit_log[v0 + i]), int'(e));
        if (spacing && i > 0) begin
          check($sformatf("%s_gap%0d", tag, i), valid_cyc[v0 + i] - valid_cyc[v0 + i - 1], 2 * HALF);
        end
      end
    end
    check($sformatf("%s_code_err", tag), n_err - e0, exp_err);
    check($sformatf("%s_frame_end", tag), n_end - f0, exp_end);
    check($sformatf("%s_unlocked", tag), int'(locked), 0);
    exp_q.delete();
  endtask

  initial begin
    int         v0;
    int         e0;
    int         f0;
    int         l0;
    int         vr;
    int         er;
    int         fr;
    logic [15:0] word;

    reset_n = 1'b0;
    line_in = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with the line toggling.
    for (int i = 0; i < 10; i++) begin
      line_in = ~line_in;
      @(posedge clk);
      #1;
    end
    check("rst_hold_outs", outs(), 0);
    line_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rst_release_outs", outs(), 0);
    check("rst_no_pulses", n_valid + n_err + n_end, 0);

    // Nominal frame: start + 1,0,1,1 + idle.
    v0 = n_valid; e0 = n_err; f0 = n_end;
    send_sym(SYM_ZERO, HALF, HALF);
    send_bit(1'b1, HALF, HALF);
    check("t1_locked", int'(locked), 1);
    send_bit(1'b0, HALF, HALF);
    send_bit(1'b1, HALF, HALF);
    send_bit(1'b1, HALF, HALF);
    half(1'b0, 24);
    check_frame("t1", v0, e0, f0, 0, 1, 1'b1);

    // Illegal start symbol "11".
    v0 = n_valid; e0 = n_err; f0 = n_end; l0 = n_lock_cyc;
    send_sym(SYM_BAD, HALF, HALF);
    half(1'b0, 24);
    check_frame("t2", v0, e0, f0, 1, 0, 1'b0);
    check("t2_never_locked", n_lock_cyc - l0, 0);

    // Start + 0 + "11" aborts with code_err after one bit.
    v0 = n_valid; e0 = n_err; f0 = n_end;
    send_sym(SYM_ZERO, HALF, HALF);
    send_bit(1'b0, HALF, HALF);
    send_sym(SYM_BAD, HALF, HALF);
    half(1'b0, 24);
    check_frame("t3a", v0, e0, f0, 1, 0, 1'b0);

    v0 = n_valid; e0 = n_err; f0 = n_end;
    send_sym(SYM_ZERO, HALF, HALF);
    send_bit(1'b1, HALF, HALF);
    half(1'b0, 24);
    check_frame("t3b", v0, e0, f0, 0, 1, 1'b0);

    // Jittered halves (3 then 5 clk) carrying 0xA5C3 MSB first.
    v0 = n_valid; e0 = n_err; f0 = n_end;
    word = 16'hA5C3;
    send_sym(SYM_ZERO, 3, 5);
    for (int i = 15; i >= 0; i--) begin
      send_bit(word[i], 3, 5);
    end
    half(1'b0, 24);
    check_frame("t4", v0, e0, f0, 0, 1, 1'b0);

    // Reset pulsed in the middle of data bit 3.
    v0 = n_valid; e0 = n_err; f0 = n_end;
    send_sym(SYM_ZERO, HALF, HALF);
    send_bit(1'b1, HALF, HALF);
    send_bit(1'b0, HALF, HALF);
    send_bit(1'b1, HALF, HALF);
    half(1'b0, HALF);
    half(1'b1, 2);
    check("t5_locked_pre", int'(locked), 1);
    check("t5_bit_out_pre", int'(bit_out), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_outs", outs(), 0);
    vr = n_valid; er = n_err; fr = n_end;
    line_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_pulses", (n_valid - vr) + (n_err - er) + (n_end - fr), 0);
    check_frame("t5a", v0, e0, f0, 0, 0, 1'b0);

    v0 = n_valid; e0 = n_err; f0 = n_end;
    send_sym(SYM_ZERO, HALF, HALF);
    send_bit(1'b0, HALF, HALF);
    send_bit(1'b1, HALF, HALF);
    half(1'b0, 24);
    check_frame("t5b", v0, e0, f0, 0, 1, 1'b0);

    check("pulse_exclusive", n_excl, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
